// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the 4x4 systolic input skew scheduler.
package systolic_pkg;

  localparam int N         = 4;
  localparam int NUM_STEPS = 2 * N - 1;
  localparam int STEP_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DONE
  } state_t;

endpackage

// File: rtl/sched_step_timer.sv
// Divides clk into a one-cycle step tick every DELAY enabled cycles; clear restarts the count.
module sched_step_timer #(
  parameter int DELAY = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(DELAY + 1);

  logic [CW-1:0] cycle_cnt;

  // The tick is decoded from the count so the step load lands exactly on the DELAY-th edge.
  assign tick = enable && (cycle_cnt == CW'(DELAY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (clear) begin
      cycle_cnt <= '0;
    end else if (enable) begin
      if (tick) cycle_cnt <= '0;
      else      cycle_cnt <= cycle_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/systolic_scheduler.sv
// Skews two 4x4 operand matrices into 7 diagonal wavefronts for an output-stationary array.
// Optional macro SYSTOLIC_SCHED_CLEAR_IDLE_EN: zero the edge feeds whenever valid is low.
module systolic_scheduler
  import systolic_pkg::*;
#(
  parameter int DELAY      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mat_a_00, mat_a_01, mat_a_02, mat_a_03,
  input  logic [DATA_WIDTH-1:0] mat_a_10, mat_a_11, mat_a_12, mat_a_13,
  input  logic [DATA_WIDTH-1:0] mat_a_20, mat_a_21, mat_a_22, mat_a_23,
  input  logic [DATA_WIDTH-1:0] mat_a_30, mat_a_31, mat_a_32, mat_a_33,
  input  logic [DATA_WIDTH-1:0] mat_b_00, mat_b_01, mat_b_02, mat_b_03,
  input  logic [DATA_WIDTH-1:0] mat_b_10, mat_b_11, mat_b_12, mat_b_13,
  input  logic [DATA_WIDTH-1:0] mat_b_20, mat_b_21, mat_b_22, mat_b_23,
  input  logic [DATA_WIDTH-1:0] mat_b_30, mat_b_31, mat_b_32, mat_b_33,
  output logic [DATA_WIDTH-1:0] a_out0,
  output logic [DATA_WIDTH-1:0] a_out1,
  output logic [DATA_WIDTH-1:0] a_out2,
  output logic [DATA_WIDTH-1:0] a_out3,
  output logic [DATA_WIDTH-1:0] b_out0,
  output logic [DATA_WIDTH-1:0] b_out1,
  output logic [DATA_WIDTH-1:0] b_out2,
  output logic [DATA_WIDTH-1:0] b_out3,
  output logic                  valid,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] mat_a [N][N];
  logic [DATA_WIDTH-1:0] mat_b [N][N];
  logic [DATA_WIDTH-1:0] a_sel [N];
  logic [DATA_WIDTH-1:0] b_sel [N];
  logic [DATA_WIDTH-1:0] a_q   [N];
  logic [DATA_WIDTH-1:0] b_q   [N];

  state_t            state;
  logic              feeding;
  logic [STEP_W-1:0] step_cnt;
  logic              step_tick;
  logic              start_acc;

  assign mat_a[0][0] = mat_a_00; assign mat_a[0][1] = mat_a_01; assign mat_a[0][2] = mat_a_02; assign mat_a[0][3] = mat_a_03;
  assign mat_a[1][0] = mat_a_10; assign mat_a[1][1] = mat_a_11; assign mat_a[1][2] = mat_a_12; assign mat_a[1][3] = mat_a_13;
  assign mat_a[2][0] = mat_a_20; assign mat_a[2][1] = mat_a_21; assign mat_a[2][2] = mat_a_22; assign mat_a[2][3] = mat_a_23;
  assign mat_a[3][0] = mat_a_30; assign mat_a[3][1] = mat_a_31; assign mat_a[3][2] = mat_a_32; assign mat_a[3][3] = mat_a_33;
  assign mat_b[0][0] = mat_b_00; assign mat_b[0][1] = mat_b_01; assign mat_b[0][2] = mat_b_02; assign mat_b[0][3] = mat_b_03;
  assign mat_b[1][0] = mat_b_10; assign mat_b[1][1] = mat_b_11; assign mat_b[1][2] = mat_b_12; assign mat_b[1][3] = mat_b_13;
  assign mat_b[2][0] = mat_b_20; assign mat_b[2][1] = mat_b_21; assign mat_b[2][2] = mat_b_22; assign mat_b[2][3] = mat_b_23;
  assign mat_b[3][0] = mat_b_30; assign mat_b[3][1] = mat_b_31; assign mat_b[3][2] = mat_b_32; assign mat_b[3][3] = mat_b_33;

  assign a_out0 = a_q[0];
  assign a_out1 = a_q[1];
  assign a_out2 = a_q[2];
  assign a_out3 = a_q[3];
  assign b_out0 = b_q[0];
  assign b_out1 = b_q[1];
  assign b_out2 = b_q[2];
  assign b_out3 = b_q[3];

  assign start_acc = start && (state == IDLE);

  sched_step_timer #(
    .DELAY (DELAY)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_acc),
    .enable (feeding),
    .tick   (step_tick)
  );

  // Wavefront s puts A[r][s-r] on row r and B[s-c][c] on column c; off-diagonal slots feed 0.
  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_sel[k] = '0;
      b_sel[k] = '0;
    end
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        if (int'(step_cnt) == r + j) a_sel[r] = mat_a[r][j];
      end
    end
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < N; i++) begin
        if (int'(step_cnt) == i + c) b_sel[c] = mat_b[i][c];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      feeding  <= 1'b0;
      step_cnt <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
    end else begin
      valid <= 1'b0;
`ifdef SYSTOLIC_SCHED_CLEAR_IDLE_EN
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FEED;
            feeding  <= 1'b1;
            step_cnt <= '0;
            a_q      <= '{default: '0};
            b_q      <= '{default: '0};
          end
        end
        FEED: begin
          if (step_tick) begin
            a_q   <= a_sel;
            b_q   <= b_sel;
            valid <= 1'b1;
            if (step_cnt == STEP_W'(NUM_STEPS - 1)) begin
              state    <= DONE;
              feeding  <= 1'b0;
              step_cnt <= '0;
            end else begin
              step_cnt <= step_cnt + STEP_W'(1);
            end
          end
        end
        DONE: begin
          // start here is only an acknowledge; a fresh pulse from IDLE begins the next run.
          if (start) begin
            state <= IDLE;
            done  <= 1'b0;
          end else begin
            done  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          feeding <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Directed bench for systolic_scheduler: DELAY=10 and DELAY=1 instances sharing one operand set.
module tb_systolic_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start10, start1;
  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];
  logic [31:0] a10 [4], b10 [4], a1 [4], b1 [4];
  logic        valid10, done10, valid1, done1;

  logic        sel1;
  logic        sv, sd, sf;
  logic [31:0] sa [4], sb [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_scheduler #(.DELAY(10), .DATA_WIDTH(32)) d10 (
    .clk(clk), .rst(rst), .start(start10),
    .mat_a_00(ma[0][0]), .mat_a_01(ma[0][1]), .mat_a_02(ma[0][2]), .mat_a_03(ma[0][3]),
    .mat_a_10(ma[1][0]), .mat_a_11(ma[1][1]), .mat_a_12(ma[1][2]), .mat_a_13(ma[1][3]),
    .mat_a_20(ma[2][0]), .mat_a_21(ma[2][1]), .mat_a_22(ma[2][2]), .mat_a_23(ma[2][3]),
    .mat_a_30(ma[3][0]), .mat_a_31(ma[3][1]), .mat_a_32(ma[3][2]), .mat_a_33(ma[3][3]),
    .mat_b_00(mb[0][0]), .mat_b_01(mb[0][1]), .mat_b_02(mb[0][2]), .mat_b_03(mb[0][3]),
    .mat_b_10(mb[1][0]), .mat_b_11(mb[1][1]), .mat_b_12(mb[1][2]), .mat_b_13(mb[1][3]),
    .mat_b_20(mb[2][0]), .mat_b_21(mb[2][1]), .mat_b_22(mb[2][2]), .mat_b_23(mb[2][3]),
    .mat_b_30(mb[3][0]), .mat_b_31(mb[3][1]), .mat_b_32(mb[3][2]), .mat_b_33(mb[3][3]),
    .a_out0(a10[0]), .a_out1(a10[1]), .a_out2(a10[2]), .a_out3(a10[3]),
    .b_out0(b10[0]), .b_out1(b10[1]), .b_out2(b10[2]), .b_out3(b10[3]),
    .valid(valid10), .done(done10)
  );

  systolic_scheduler #(.DELAY(1), .DATA_WIDTH(32)) d1 (
    .clk(clk), .rst(rst), .start(start1),
    .mat_a_00(ma[0][0]), .mat_a_01(ma[0][1]), .mat_a_02(ma[0][2]), .mat_a_03(ma[0][3]),
    .mat_a_10(ma[1][0]), .mat_a_11(ma[1][1]), .mat_a_12(ma[1][2]), .mat_a_13(ma[1][3]),
    .mat_a_20(ma[2][0]), .mat_a_21(ma[2][1]), .mat_a_22(ma[2][2]), .mat_a_23(ma[2][3]),
    .mat_a_30(ma[3][0]), .mat_a_31(ma[3][1]), .mat_a_32(ma[3][2]), .mat_a_33(ma[3][3]),
    .mat_b_00(mb[0][0]), .mat_b_01(mb[0][1]), .mat_b_02(mb[0][2]), .mat_b_03(mb[0][3]),
    .mat_b_10(mb[1][0]), .mat_b_11(mb[1][1]), .mat_b_12(mb[1][2]), .mat_b_13(mb[1][3]),
    .mat_b_20(mb[2][0]), .mat_b_21(mb[2][1]), .mat_b_22(mb[2][2]), .mat_b_23(mb[2][3]),
    .mat_b_30(mb[3][0]), .mat_b_31(mb[3][1]), .mat_b_32(mb[3][2]), .mat_b_33(mb[3][3]),
    .a_out0(a1[0]), .a_out1(a1[1]), .a_out2(a1[2]), .a_out3(a1[3]),
    .b_out0(b1[0]), .b_out1(b1[1]), .b_out2(b1[2]), .b_out3(b1[3]),
    .valid(valid1), .done(done1)
  );

  always_comb begin
    sv = sel1 ? valid1 : valid10;
    sd = sel1 ? done1  : done10;
    sf = sel1 ? d1.feeding : d10.feeding;
    for (int r = 0; r < 4; r++) begin
      sa[r] = sel1 ? a1[r] : a10[r];
      sb[r] = sel1 ? b1[r] : b10[r];
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] v [4]);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Wavefront s: row r carries A[r][s-r], column c carries B[s-c][c].
  function automatic logic [127:0] exp_a(input int s);
    logic [31:0] v [4];
    for (int r = 0; r < 4; r++) begin
      v[r] = '0;
      if (s - r >= 0 && s - r <= 3) v[r] = ma[r][s-r];
    end
    return pk(v);
  endfunction

  function automatic logic [127:0] exp_b(input int s);
    logic [31:0] v [4];
    for (int c = 0; c < 4; c++) begin
      v[c] = '0;
      if (s - c >= 0 && s - c <= 3) v[c] = mb[s-c][c];
    end
    return pk(v);
  endfunction

  task automatic drive_start(input bit v);
    if (sel1) start1 = v;
    else      start10 = v;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    drive_start(1'b1);
    step_cycle();
    drive_start(1'b0);
  endtask

  // Starts an operation from IDLE and checks every cycle until well past done.
  task automatic run_op(input int dly, input bit poke);
    logic [127:0] hold_a = '0;
    logic [127:0] hold_b = '0;
    int pulses = 0;
    pulse_start();
    for (int k = 0; k <= 8 * dly + 3; k++) begin
      bit ev;
      int s;
      ev = (k % dly == 0) && (k / dly >= 1) && (k / dly <= 7);
      s  = k / dly - 1;
      check("valid", sv, ev);
      check("done", sd, k >= 7 * dly + 1);
      check("feeding", sf, k < 7 * dly);
      if (ev) begin
        pulses++;
        hold_a = exp_a(s);
        hold_b = exp_b(s);
        check("a_step", pk(sa), hold_a);
        check("b_step", pk(sb), hold_b);
        if (s == 0) begin
          check("a_s0", pk(sa), 128'h00000001_00000000_00000000_00000000);
          check("b_s0", pk(sb), 128'h00000011_00000000_00000000_00000000);
        end
        if (s == 3) begin
          check("a_s3", pk(sa), 128'h00000004_00000007_0000000A_0000000D);
          check("b_s3", pk(sb), 128'h0000001D_0000001A_00000017_00000014);
        end
        if (s == 6) begin
          check("a_s6", pk(sa), 128'h00000000_00000000_00000000_00000010);
          check("b_s6", pk(sb), 128'h00000000_00000000_00000000_00000020);
        end
      end else begin
`ifdef SYSTOLIC_SCHED_CLEAR_IDLE_EN
        check("a_idle_zero", pk(sa), '0);
        check("b_idle_zero", pk(sb), '0);
`else
        check("a_hold", pk(sa), hold_a);
        check("b_hold", pk(sb), hold_b);
`endif
      end
      drive_start(poke && (k == 3 * dly + 2));
      step_cycle();
    end
    drive_start(1'b0);
    check("pulse_count", pulses, 7);
  endtask

  // Acknowledge in DONE: done must fall on that edge and no feeding follows.
  task automatic ack_done();
    int pulses = 0;
    check("done_before_ack", sd, 1'b1);
    pulse_start();
    check("done_after_ack", sd, 1'b0);
    check("valid_after_ack", sv, 1'b0);
    for (int k = 0; k < 25; k++) begin
      if (sv) pulses++;
      step_cycle();
    end
    check("ack_no_valid", pulses, 0);
    check("ack_done_low", sd, 1'b0);
    check("ack_feeding_low", sf, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start10 = 1'b0; start1 = 1'b0; sel1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 32'(1 + 4 * i + j);
        mb[i][j] = 32'(17 + 4 * i + j);
      end
    end
    repeat (3) step_cycle();
    check("rst_valid10", valid10, 1'b0);
    check("rst_done10", done10, 1'b0);
    check("rst_a10", pk(a10), '0);
    check("rst_b10", pk(b10), '0);
    check("rst_feeding10", d10.feeding, 1'b0);
    check("rst_valid1", valid1, 1'b0);
    check("rst_done1", done1, 1'b0);
    rst = 1'b0;
    step_cycle();

    // DELAY=10: clean run, acknowledge, then a run with a start poke in FEED.
    run_op(10, 1'b0);
    ack_done();
    run_op(10, 1'b1);
    ack_done();

    // Mid-operation reset: outputs clear asynchronously and stay clear after release.
    pulse_start();
    repeat (30) step_cycle();
    check("pre_rst_a_nonzero", pk(a10) != '0 || pk(b10) != '0 || 1'b0, 1'b1
`ifdef SYSTOLIC_SCHED_CLEAR_IDLE_EN
          & 1'b0
`endif
          );
    rst = 1'b1;
    #1;
    check("async_valid", valid10, 1'b0);
    check("async_done", done10, 1'b0);
    check("async_a", pk(a10), '0);
    check("async_b", pk(b10), '0);
    step_cycle();
    rst = 1'b0;
    step_cycle();
    check("post_rst_valid", valid10, 1'b0);
    check("post_rst_done", done10, 1'b0);
    check("post_rst_a", pk(a10), '0);
    check("post_rst_b", pk(b10), '0);
    check("post_rst_feeding", d10.feeding, 1'b0);
    repeat (12) step_cycle();
    check("post_rst_idle_valid", valid10, 1'b0);
    run_op(10, 1'b0);

    // DELAY=1: valid on 7 consecutive cycles, done on the 8th.
    sel1 = 1'b1;
    run_op(1, 1'b0);
    ack_done();
    run_op(1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
